// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and board field widths for the tile
// scan pipeline.
package vga_pkg;

  localparam int H_VISIBLE    = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int H_TOTAL      = 800;

  localparam int V_VISIBLE    = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;
  localparam int V_TOTAL      = 525;

  localparam int BOARD_W = 64;
  localparam int EXP_W   = 4;
  localparam int POS_W   = 5;
  localparam int CNT_W   = 11;

  // Origin of tile column/row idx along one axis, evaluated at elaboration only.
  function automatic int tile_origin(input int base, input int pitch, input int idx);
    return base + pitch * idx;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider, h/v counters and registered sync/valid. Also exposes the
// next counter values so downstream decode can register in lockstep.
module vga_timing
  import vga_pkg::*;
#(
  parameter int PIX_DIV = 4,
  parameter int H_VIS   = H_VISIBLE,
  parameter int H_SS    = H_SYNC_START,
  parameter int H_SE    = H_SYNC_END,
  parameter int H_TOT   = H_TOTAL,
  parameter int V_VIS   = V_VISIBLE,
  parameter int V_SS    = V_SYNC_START,
  parameter int V_SE    = V_SYNC_END,
  parameter int V_TOT   = V_TOTAL
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              tick,
  output logic [CNT_W-1:0]  h_next,
  output logic [CNT_W-1:0]  v_next,
  output logic              vis_next,
  output logic [CNT_W-1:0]  h_cnt,
  output logic [CNT_W-1:0]  v_cnt,
  output logic              hsync,
  output logic              vsync,
  output logic              valid
);

  localparam logic [3:0]       DIV_LAST = 4'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] H_SS_C   = CNT_W'(H_SS);
  localparam logic [CNT_W-1:0] H_SE_C   = CNT_W'(H_SE);
  localparam logic [CNT_W-1:0] V_SS_C   = CNT_W'(V_SS);
  localparam logic [CNT_W-1:0] V_SE_C   = CNT_W'(V_SE);

  logic [3:0]       div_reg;
  logic [CNT_W-1:0] h_reg;
  logic [CNT_W-1:0] v_reg;
  logic             hsync_reg;
  logic             vsync_reg;
  logic             valid_reg;
  logic             h_wrap;

  assign tick     = (div_reg == DIV_LAST);
  assign h_wrap   = (h_reg == H_LAST);
  assign h_next   = h_wrap ? '0 : h_reg + 1'b1;
  assign v_next   = !h_wrap ? v_reg : ((v_reg == V_LAST) ? '0 : v_reg + 1'b1);
  assign vis_next = (h_next < H_VIS_C) && (v_next < V_VIS_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg   <= '0;
      h_reg     <= '0;
      v_reg     <= '0;
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
      valid_reg <= 1'b1;
    end else begin
      div_reg <= tick ? '0 : div_reg + 1'b1;
      // Sync/valid come from next values so they line up with the new counters.
      if (tick) begin
        h_reg     <= h_next;
        v_reg     <= v_next;
        hsync_reg <= !((h_next >= H_SS_C) && (h_next <= H_SE_C));
        vsync_reg <= !((v_next >= V_SS_C) && (v_next <= V_SE_C));
        valid_reg <= vis_next;
      end
    end
  end

  assign h_cnt = h_reg;
  assign v_cnt = v_reg;
  assign hsync = hsync_reg;
  assign vsync = vsync_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/vga_tile_scan.sv
// VGA timing plus 4x4 tile classification and a per-frame board snapshot, so
// h_cnt/v_cnt/curpos/curdata always describe the same pixel.
module vga_tile_scan
  import vga_pkg::*;
#(
  parameter int PIX_DIV    = 4,
  parameter int TILE_W     = 80,
  parameter int TILE_PITCH = 96,
  parameter int X0         = 136,
  parameter int Y0         = 66,
  parameter int H_VIS      = H_VISIBLE,
  parameter int H_SS       = H_SYNC_START,
  parameter int H_SE       = H_SYNC_END,
  parameter int H_TOT      = H_TOTAL,
  parameter int V_VIS      = V_VISIBLE,
  parameter int V_SS       = V_SYNC_START,
  parameter int V_SE       = V_SYNC_END,
  parameter int V_TOT      = V_TOTAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] board_in,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [4:0]  curpos,
  output logic [3:0]  curdata,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] V_SNAP = CNT_W'(V_VIS);

  logic             tick;
  logic             vis_next;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;

  vga_timing #(
    .PIX_DIV (PIX_DIV),
    .H_VIS   (H_VIS),
    .H_SS    (H_SS),
    .H_SE    (H_SE),
    .H_TOT   (H_TOT),
    .V_VIS   (V_VIS),
    .V_SS    (V_SS),
    .V_SE    (V_SE),
    .V_TOT   (V_TOT)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .h_next   (h_next),
    .v_next   (v_next),
    .vis_next (vis_next),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .hsync    (hsync),
    .vsync    (vsync),
    .valid    (valid)
  );

  logic [3:0] col_hit;
  logic [3:0] row_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_origin
      localparam int XL = tile_origin(X0, TILE_PITCH, gi);
      localparam int YL = tile_origin(Y0, TILE_PITCH, gi);
      localparam logic [CNT_W-1:0] X_LO = CNT_W'(XL);
      localparam logic [CNT_W-1:0] X_HI = CNT_W'(XL + TILE_W);
      localparam logic [CNT_W-1:0] Y_LO = CNT_W'(YL);
      localparam logic [CNT_W-1:0] Y_HI = CNT_W'(YL + TILE_W);
      assign col_hit[gi] = (h_next >= X_LO) && (h_next < X_HI);
      assign row_hit[gi] = (v_next >= Y_LO) && (v_next < Y_HI);
    end
  endgenerate

  logic [1:0]         col_idx;
  logic [1:0]         row_idx;
  logic [3:0]         tile_idx;
  logic               tile_hit;
  logic [POS_W-1:0]   pos_next;
  logic [EXP_W-1:0]   data_next;
  logic               snap_hit;
  logic [BOARD_W-1:0] snap_reg;
  logic [POS_W-1:0]   curpos_reg;
  logic [EXP_W-1:0]   curdata_reg;
  logic               frame_tick_reg;

  always_comb begin
    col_idx = 2'd0;
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (col_hit[i]) col_idx = 2'(i);
      if (row_hit[i]) row_idx = 2'(i);
    end
  end

  assign tile_hit  = (|col_hit) && (|row_hit) && vis_next;
  assign tile_idx  = {row_idx, col_idx};
  assign pos_next  = tile_hit ? {1'b0, tile_idx} + 5'd1 : '0;
  // Reads the snapshot held before any update this tick; updates only land at v=V_VIS.
  assign data_next = tile_hit ? snap_reg[{tile_idx, 2'b00} +: EXP_W] : '0;
  assign snap_hit  = tick && (h_next == '0) && (v_next == V_SNAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_reg       <= '0;
      curpos_reg     <= '0;
      curdata_reg    <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= snap_hit;
      if (snap_hit) snap_reg <= board_in;
      if (tick) begin
        curpos_reg  <= pos_next;
        curdata_reg <= data_next;
      end
    end
  end

  assign curpos     = curpos_reg;
  assign curdata    = curdata_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_tile_scan.sv
// Scoreboard bench: a reduced-geometry instance exercises frames, snapshots and
// reset; a full 640x480 instance at PIX_DIV=1 checks line timing and row-0 tiles.
module tb_vga_tile_scan;

  typedef struct {
    int pix_div;
    int htot, hvis, hss, hse;
    int vtot, vvis, vss, vse;
    int x0, y0, pitch, w;
  } geom_t;

  typedef struct {
    int          div, h, v;
    logic [63:0] snap;
  } mstate_t;

  typedef struct {
    int h, v, pos, data;
    bit hs, vs, vld, ft;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_f_n;
  logic [63:0] board;

  logic [10:0] s_h, s_v, f_h, f_v;
  logic        s_hs, s_vs, s_vld, s_ft, f_hs, f_vs, f_vld, f_ft;
  logic [4:0]  s_pos, f_pos;
  logic [3:0]  s_data, f_data;

  int total = 0;
  int bad   = 0;

  geom_t   gs = '{4, 50, 40, 44, 47, 36, 30, 33, 34, 10, 3, 6, 4};
  geom_t   gf = '{1, 800, 640, 656, 751, 525, 480, 490, 491, 136, 66, 96, 80};
  mstate_t ms = '{div: 0, h: 0, v: 0, snap: 64'h0};
  mstate_t mf = '{div: 0, h: 0, v: 0, snap: 64'h0};
  exp_t    es, ef;
  exp_t    qs[$];
  exp_t    qf[$];

  int s_ft_cnt   = 0;
  int exp_ft_cnt = 0;
  int hs_low     = 0;
  bit hs_checked = 0;

  int pt_h[6]   = '{135, 136, 215, 216, 232, 136};
  int pt_v[6]   = '{66, 66, 66, 66, 66, 65};
  int pt_pos[6] = '{0, 1, 1, 0, 2, 0};

  always #5 clk = ~clk;

  vga_tile_scan #(
    .PIX_DIV(4), .TILE_W(4), .TILE_PITCH(6), .X0(10), .Y0(3),
    .H_VIS(40), .H_SS(44), .H_SE(47), .H_TOT(50),
    .V_VIS(30), .V_SS(33), .V_SE(34), .V_TOT(36)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .board_in(board),
    .h_cnt(s_h), .v_cnt(s_v), .hsync(s_hs), .vsync(s_vs), .valid(s_vld),
    .curpos(s_pos), .curdata(s_data), .frame_tick(s_ft)
  );

  vga_tile_scan #(.PIX_DIV(1)) u_full (
    .clk(clk), .rst_n(rst_f_n), .board_in(board),
    .h_cnt(f_h), .v_cnt(f_v), .hsync(f_hs), .vsync(f_vs), .valid(f_vld),
    .curpos(f_pos), .curdata(f_data), .frame_tick(f_ft)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference decode by division/modulo over the tile lattice.
  function automatic int exp_pos(input geom_t g, input int h, input int v);
    int c, r;
    if (h >= g.hvis || v >= g.vvis || h < g.x0 || v < g.y0) return 0;
    c = (h - g.x0) / g.pitch;
    r = (v - g.y0) / g.pitch;
    if (c > 3 || r > 3) return 0;
    if ((h - g.x0) % g.pitch >= g.w || (v - g.y0) % g.pitch >= g.w) return 0;
    return 4 * r + c + 1;
  endfunction

  function automatic exp_t outputs_at(input geom_t g, input int h, input int v,
                                      input logic [63:0] snap);
    exp_t e;
    e.h    = h;
    e.v    = v;
    e.hs   = !(h >= g.hss && h <= g.hse);
    e.vs   = !(v >= g.vss && v <= g.vse);
    e.vld  = (h < g.hvis) && (v < g.vvis);
    e.pos  = exp_pos(g, h, v);
    e.data = (e.pos == 0) ? 0 : int'(snap[4 * (e.pos - 1) +: 4]);
    e.ft   = 1'b0;
    return e;
  endfunction

  function automatic void model_step(input geom_t g, input logic rst_ni,
                                     input logic [63:0] brd, input mstate_t si,
                                     input exp_t ei, output mstate_t so,
                                     output exp_t eo);
    so    = si;
    eo    = ei;
    eo.ft = 1'b0;
    if (!rst_ni) begin
      so = '{div: 0, h: 0, v: 0, snap: 64'h0};
      eo = outputs_at(g, 0, 0, 64'h0);
      return;
    end
    if (si.div == g.pix_div - 1) begin
      so.div = 0;
      so.h   = si.h + 1;
      if (so.h == g.htot) begin
        so.h = 0;
        so.v = (si.v + 1 == g.vtot) ? 0 : si.v + 1;
      end
      eo = outputs_at(g, so.h, so.v, si.snap);
      if (so.h == 0 && so.v == g.vvis) begin
        so.snap = brd;
        eo.ft   = 1'b1;
      end
    end else begin
      so.div = si.div + 1;
    end
  endfunction

  task automatic cmp_out(input string who, input exp_t e,
                         input logic [10:0] h, input logic [10:0] v,
                         input logic hs, input logic vs, input logic vld,
                         input logic [4:0] pos, input logic [3:0] data, input logic ft);
    check({who, ".h_cnt"},      64'(h),    64'(e.h));
    check({who, ".v_cnt"},      64'(v),    64'(e.v));
    check({who, ".hsync"},      64'(hs),   64'(e.hs));
    check({who, ".vsync"},      64'(vs),   64'(e.vs));
    check({who, ".valid"},      64'(vld),  64'(e.vld));
    check({who, ".curpos"},     64'(pos),  64'(e.pos));
    check({who, ".curdata"},    64'(data), 64'(e.data));
    check({who, ".frame_tick"}, 64'(ft),   64'(e.ft));
  endtask

  always @(posedge clk) begin
    model_step(gs, rst_n, board, ms, es, ms, es);
    model_step(gf, rst_f_n, board, mf, ef, mf, ef);
    qs.push_back(es);
    qf.push_back(ef);
  end

  always @(negedge clk) begin : chk
    exp_t e;
    if (qs.size() == 0) begin
      check("s.queue", 64'(qs.size()), 64'd1);
    end else begin
      e = qs.pop_front();
      cmp_out("s", e, s_h, s_v, s_hs, s_vs, s_vld, s_pos, s_data, s_ft);
      if (e.ft) exp_ft_cnt++;
      if (s_ft === 1'b1) begin
        s_ft_cnt++;
        $display("frame_tick #%0d at t=%0t h=%0d v=%0d", s_ft_cnt, $time, s_h, s_v);
      end
    end
    if (qf.size() == 0) begin
      check("f.queue", 64'(qf.size()), 64'd1);
    end else begin
      e = qf.pop_front();
      cmp_out("f", e, f_h, f_v, f_hs, f_vs, f_vld, f_pos, f_data, f_ft);
      if (rst_f_n && e.v == 0 && f_hs === 1'b0) hs_low++;
      if (e.v == 1 && e.h == 0 && !hs_checked) begin
        check("f.hsync_width", 64'(hs_low), 64'd96);
        $display("line 0 hsync low for %0d ticks", hs_low);
        hs_checked = 1'b1;
      end
      for (int i = 0; i < 6; i++) begin
        if (e.h == pt_h[i] && e.v == pt_v[i]) begin
          check("f.point_curpos", 64'(f_pos), 64'(pt_pos[i]));
          $display("point (%0d,%0d) curpos=%0d curdata=%0d", pt_h[i], pt_v[i], f_pos, f_data);
        end
      end
    end
  end

  task automatic wait_ft(input int n, input int budget);
    int i = 0;
    while (s_ft_cnt < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (s_ft_cnt < n) check("wait_frame_tick", 64'(s_ft_cnt), 64'(n));
  endtask

  task automatic wait_pos(input int h, input int v, input int budget);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(ms.h == h && ms.v == v) && i < budget);
    if (!(ms.h == h && ms.v == v)) check("wait_pos", 64'(ms.v), 64'(v));
  endtask

  initial begin
    rst_n   = 1'b0;
    rst_f_n = 1'b0;
    board   = 64'hFEDCBA9876543210;
    repeat (3) @(negedge clk);
    #1;
    rst_n   = 1'b1;
    rst_f_n = 1'b1;
    $display("reset released at t=%0t", $time);

    wait_ft(1, 10000);
    wait_pos(0, 12, 8000);
    #1;
    board = 64'h0123456789ABCDEF;
    $display("board changed mid-frame at v=12 t=%0t", $time);
    wait_ft(2, 10000);

    // Async reset while sitting on a populated tile.
    wait_pos(17, 16, 8000);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst.h_cnt",      64'(s_h),    64'd0);
    check("rst.v_cnt",      64'(s_v),    64'd0);
    check("rst.hsync",      64'(s_hs),   64'd1);
    check("rst.vsync",      64'(s_vs),   64'd1);
    check("rst.valid",      64'(s_vld),  64'd1);
    check("rst.curpos",     64'(s_pos),  64'd0);
    check("rst.curdata",    64'(s_data), 64'd0);
    check("rst.frame_tick", 64'(s_ft),   64'd0);
    $display("async reset asserted at t=%0t", $time);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;

    wait_ft(3, 10000);
    repeat (7200) @(negedge clk);

    for (int i = 0; i < 60000 && mf.v < 67; i++) @(negedge clk);
    check("f.reached_line", 64'(mf.v >= 67), 64'd1);
    check("f.hsync_seen",   64'(hs_checked), 64'd1);
    check("s.ft_count",     64'(s_ft_cnt),   64'(exp_ft_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
